avmm_csr_slave: RTL and testbench

AVMM_CSR_SLAVE -- requirements
Module: avmm_csr_slave

---
 rtl/avmm_csr_slave.sv | 178 +++++++++++++++++
 tb/tb_avmm_csr_slave.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_csr_slave.sv
// Avalon-MM CSR slave: lower NREGS/2 words are RW control, upper NREGS/2 are RO status.
// Define AVMM_CSR_ADDR_CHECK_EN to reject unwrapped beat addresses >= NREGS and flag addr_err.
module avmm_csr_slave #(
    parameter int unsigned AW        = 16,
    parameter int unsigned DW        = 64,
    parameter int unsigned MAX_BURST = 1,
    parameter int unsigned NREGS     = 16,
    localparam int unsigned BCW      = $clog2(MAX_BURST),
    localparam int unsigned NC       = NREGS / 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AW-1:0]        avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [BCW:0]         avs_burstcount,
    input  logic [DW-1:0]        avs_writedata,
    input  logic [DW/8-1:0]      avs_byteenable,
    output logic                 avs_waitrequest,
    output logic [DW-1:0]        avs_readdata,
    output logic                 avs_readdatavalid,
    output logic [NC*DW-1:0]     ctrl_q,
    output logic [NC-1:0]        ctrl_wr,
    input  logic [NC*DW-1:0]     sts_d,
    output logic                 addr_err
);

    localparam int unsigned IW = $clog2(NREGS);
    localparam logic [BCW:0] BcOne = (BCW + 1)'(1);
    localparam logic [AW:0] AddrOne = (AW + 1)'(1);

    typedef enum logic [1:0] {StIdle, StWburst, StRburst} state_e;

    state_e          state_q, state_d;
    logic [BCW:0]    len, rem_q;
    logic [AW:0]     ptr_q, cur_addr;
    logic [IW-1:0]   idx;
    logic            wr_beat, rd_beat, start_burst, oor;
    logic [DW-1:0]   ctrl_mem_q [NC];
    logic [DW-1:0]   rd_mux;
    logic [DW-1:0]   readdata_q;
    logic            rdv_q;
    logic [NC-1:0]   ctrl_wr_q;

    always_comb begin
        if (int'(avs_burstcount) == 0) begin
            len = BcOne;
        end else if (int'(avs_burstcount) > MAX_BURST) begin
            len = (BCW + 1)'(MAX_BURST);
        end else begin
            len = avs_burstcount;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (avs_write) begin
                    if (len != BcOne) state_d = StWburst;
                end else if (avs_read) begin
                    if (len != BcOne) state_d = StRburst;
                end
            end
            StWburst: if (avs_write && rem_q == BcOne) state_d = StIdle;
            StRburst: if (rem_q == BcOne) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        avs_waitrequest = 1'b0;
        wr_beat         = 1'b0;
        rd_beat         = 1'b0;
        start_burst     = 1'b0;
        unique case (state_q)
            StIdle: begin
                wr_beat     = avs_write;
                rd_beat     = avs_read & ~avs_write;
                start_burst = (avs_write | avs_read) && (len != BcOne);
            end
            StWburst: wr_beat = avs_write;
            StRburst: begin
                avs_waitrequest = 1'b1;
                rd_beat         = 1'b1;
            end
            default: ;
        endcase
    end

    // Unwrapped address of the current beat; the low IW bits select the register.
    assign cur_addr = (state_q == StIdle) ? {1'b0, avs_address} : ptr_q;
    assign idx      = cur_addr[IW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            ptr_q <= '0;
        end else if (start_burst) begin
            rem_q <= len - BcOne;
            ptr_q <= cur_addr + AddrOne;
        end else if (state_q != StIdle && (wr_beat || rd_beat)) begin
            rem_q <= rem_q - BcOne;
            ptr_q <= ptr_q + AddrOne;
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NC; i++) begin
            if (idx == IW'(i))      rd_mux = ctrl_mem_q[i];
            if (idx == IW'(i + NC)) rd_mux = sts_d[i*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NC; i++) ctrl_mem_q[i] <= '0;
            ctrl_wr_q <= '0;
        end else begin
            ctrl_wr_q <= '0;
            for (int i = 0; i < NC; i++) begin
                if (wr_beat && !oor && idx == IW'(i)) begin
                    ctrl_wr_q[i] <= 1'b1;
                    for (int b = 0; b < DW / 8; b++) begin
                        if (avs_byteenable[b]) ctrl_mem_q[i][b*8 +: 8] <= avs_writedata[b*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdv_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            rdv_q <= rd_beat;
            if (rd_beat) readdata_q <= oor ? '0 : rd_mux;
        end
    end

`ifdef AVMM_CSR_ADDR_CHECK_EN
    logic addr_err_q;

    assign oor = cur_addr >= (AW + 1)'(NREGS);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err_q <= 1'b0;
        end else if ((wr_beat || rd_beat) && oor) begin
            addr_err_q <= 1'b1;
        end
    end

    assign addr_err = addr_err_q;
`else
    assign oor      = 1'b0;
    assign addr_err = 1'b0;
`endif

    for (genvar g = 0; g < NC; g++) begin : g_ctrl_out
        assign ctrl_q[g*DW +: DW] = ctrl_mem_q[g];
    end

    assign ctrl_wr           = ctrl_wr_q;
    assign avs_readdata      = readdata_q;
    assign avs_readdatavalid = rdv_q;

endmodule

// File: tb/tb_avmm_csr_slave.sv
// Scoreboard bench for avmm_csr_slave (MAX_BURST=4, NREGS=16): reference model
// predicts read beats, ctrl_wr pulses and ctrl_q contents per cycle.
module tb_avmm_csr_slave;

    localparam int AW = 16;
    localparam int DW = 64;
    localparam int MAX_BURST = 4;
    localparam int NREGS = 16;
    localparam int NC = NREGS / 2;

    logic                clk;
    logic                rst;
    logic [AW-1:0]       avs_address;
    logic                avs_read;
    logic                avs_write;
    logic [2:0]          avs_burstcount;
    logic [DW-1:0]       avs_writedata;
    logic [DW/8-1:0]     avs_byteenable;
    logic                avs_waitrequest;
    logic [DW-1:0]       avs_readdata;
    logic                avs_readdatavalid;
    logic [NC*DW-1:0]    ctrl_q;
    logic [NC-1:0]       ctrl_wr;
    logic [NC*DW-1:0]    sts_d;
    logic                addr_err;

    avmm_csr_slave #(
        .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST), .NREGS(NREGS)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_burstcount    (avs_burstcount),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_waitrequest   (avs_waitrequest),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .ctrl_q            (ctrl_q),
        .ctrl_wr           (ctrl_wr),
        .sts_d             (sts_d),
        .addr_err          (addr_err)
    );

    typedef struct {
        int          cyc;
        logic [63:0] data;
    } rd_t;

    typedef struct {
        int           cyc;
        logic [7:0]   mask;
        logic [511:0] snap;
    } wr_t;

    rd_t          exp_rd[$];
    wr_t          exp_wr[$];
    logic [63:0]  ref_ctrl [NC];
    bit           ref_err = 0;
    logic [511:0] cur_snap = '0;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    function automatic int eff_len(input int bc);
        if (bc == 0) return 1;
        if (bc > MAX_BURST) return MAX_BURST;
        return bc;
    endfunction

    function automatic logic [511:0] snap();
        logic [511:0] s;
        for (int i = 0; i < NC; i++) s[i*64 +: 64] = ref_ctrl[i];
        return s;
    endfunction

    function automatic bit out_of_range(input int a);
`ifdef AVMM_CSR_ADDR_CHECK_EN
        return a >= NREGS;
`else
        return (a < 0);
`endif
    endfunction

    // Monitor: pops expected read beats and per-cycle control register state.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_rd.size() > 0 && exp_rd[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_beat: readdatavalid=0 at cycle %0d, required beat data %h",
                         exp_rd[0].cyc, exp_rd[0].data);
                void'(exp_rd.pop_front());
            end
            if (avs_readdatavalid) begin
                checks++;
                if (exp_rd.size() == 0 || exp_rd[0].cyc != cyc) begin
                    errors++;
                    $display("FAIL unexpected_beat: readdatavalid=1 data %h at cycle %0d, required none",
                             avs_readdata, cyc);
                end else begin
                    rd_t r;
                    r = exp_rd.pop_front();
                    if (avs_readdata !== r.data) begin
                        errors++;
                        $display("FAIL readdata: got %h at cycle %0d, required %h",
                                 avs_readdata, cyc, r.data);
                    end
                end
            end
            begin
                logic [7:0] m;
                m = '0;
                if (exp_wr.size() > 0 && exp_wr[0].cyc == cyc) begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    m = w.mask;
                    cur_snap = w.snap;
                end
                checks++;
                if (ctrl_wr !== m) begin
                    errors++;
                    $display("FAIL ctrl_wr: got %b at cycle %0d, required %b", ctrl_wr, cyc, m);
                end
                checks++;
                if (ctrl_q !== cur_snap) begin
                    errors++;
                    $display("FAIL ctrl_q: got %h at cycle %0d, required %h", ctrl_q, cyc, cur_snap);
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (avs_waitrequest !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (avs_waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL wait_ready: waitrequest=%b after 20 cycles, required 0", avs_waitrequest);
        end
        checks++;
        if (addr_err !== ref_err) begin
            errors++;
            $display("FAIL addr_err: got %b, required %b", addr_err, ref_err);
        end
    endtask

    task automatic model_write(input int a, input logic [63:0] d, input logic [7:0] be);
        int idx = a % NREGS;
        if (out_of_range(a)) begin
            ref_err = 1;
        end else if (idx < NC) begin
            for (int b = 0; b < 8; b++) if (be[b]) ref_ctrl[idx][b*8 +: 8] = d[b*8 +: 8];
            exp_wr.push_back('{cyc + 1, 8'(1 << idx), snap()});
        end
    endtask

    task automatic do_write(input int addr, input int bc, input int gap_k, input int gap_n,
                            input bit rnd, input logic [63:0] d, input logic [7:0] be,
                            input bit with_read);
        int len = eff_len(bc);
        for (int k = 0; k < len; k++) begin
            logic [63:0] wd;
            logic [7:0]  wb;
            @(negedge clk);
            if (k == gap_k && gap_n > 0) begin
                avs_write = 0;
                avs_read  = 0;
                repeat (gap_n) @(negedge clk);
            end
            wait_ready();
            wd = rnd ? {$urandom, $urandom} : d + 64'(k);
            wb = rnd ? 8'($urandom_range(255, 1)) : be;
            avs_write      = 1;
            avs_read       = with_read;
            avs_address    = AW'(addr);
            avs_burstcount = 3'(bc);
            avs_writedata  = wd;
            avs_byteenable = wb;
            model_write(addr + k, wd, wb);
        end
        @(negedge clk);
        avs_write = 0;
        avs_read  = 0;
    endtask

    task automatic do_read(input int addr, input int bc, input bit chk_wait);
        int len = eff_len(bc);
        @(negedge clk);
        wait_ready();
        for (int i = 0; i < NC; i++) sts_d[i*64 +: 64] = {$urandom, $urandom};
        avs_read       = 1;
        avs_write      = 0;
        avs_address    = AW'(addr);
        avs_burstcount = 3'(bc);
        for (int k = 0; k < len; k++) begin
            int a = addr + k;
            int idx = a % NREGS;
            logic [63:0] v;
            if (out_of_range(a)) begin
                v = '0;
                ref_err = 1;
            end else if (idx < NC) begin
                v = ref_ctrl[idx];
            end else begin
                v = sts_d[(idx - NC)*64 +: 64];
            end
            exp_rd.push_back('{cyc + 1 + k, v});
        end
        if (chk_wait) begin
            for (int j = 1; j <= len; j++) begin
                @(negedge clk);
                if (j == 1) avs_read = 0;
                checks++;
                if (avs_waitrequest !== (j < len)) begin
                    errors++;
                    $display("FAIL burst_wait: waitrequest=%b on beat %0d, required %b",
                             avs_waitrequest, j, (j < len));
                end
            end
        end else begin
            @(negedge clk);
            avs_read = 0;
        end
    endtask

    // Reset with a write command held high; the command must be ignored.
    task automatic do_reset(input int n);
        @(negedge clk);
        rst            = 1;
        avs_write      = 1;
        avs_read       = 0;
        avs_address    = 0;
        avs_burstcount = 1;
        avs_writedata  = {$urandom, $urandom};
        avs_byteenable = 8'hff;
        while (exp_rd.size() > 0 && exp_rd[$].cyc >= cyc + 1) void'(exp_rd.pop_back());
        while (exp_wr.size() > 0 && exp_wr[$].cyc >= cyc + 1) void'(exp_wr.pop_back());
        for (int i = 0; i < NC; i++) ref_ctrl[i] = '0;
        ref_err = 0;
        exp_wr.push_back('{cyc + 1, 8'h00, 512'h0});
        repeat (n - 1) @(negedge clk);
        @(negedge clk);
        rst       = 0;
        avs_write = 0;
        checks++;
        if (avs_waitrequest !== 1'b0 || avs_readdata !== '0 || addr_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: waitrequest=%b readdata=%h addr_err=%b, required 0/0/0",
                     avs_waitrequest, avs_readdata, addr_err);
        end
    endtask

    initial begin
        rst            = 1;
        avs_address    = '0;
        avs_read       = 0;
        avs_write      = 0;
        avs_burstcount = 1;
        avs_writedata  = '0;
        avs_byteenable = '0;
        sts_d          = '0;
        for (int i = 0; i < NC; i++) ref_ctrl[i] = '0;
        do_reset(2);

        // Full write then read back of reg 2.
        do_write(2, 1, -1, 0, 0, 64'h1122334455667788, 8'hff, 0);
        do_read(2, 1, 0);
        // Low-half byte enables onto a zero register.
        do_write(1, 1, -1, 0, 0, 64'hffffffffffffffff, 8'h0f, 0);
        do_read(1, 1, 0);
        // Wrapping read burst across the top of the register file.
        do_read(14, 4, 1);
        // Write burst with a two-cycle stall before the last beat.
        do_write(0, 3, 2, 2, 0, 64'hcafe0000beef0000, 8'hff, 0);
        do_read(0, 3, 0);
        // Clamped and zero burstcounts.
        do_read(5, 7, 1);
        do_read(3, 0, 0);
        // Read and write together in idle: the write wins.
        do_write(6, 1, -1, 0, 0, 64'h0123456789abcdef, 8'hff, 1);
        do_read(6, 1, 0);
        // Address beyond the register file.
        do_write(4, 1, -1, 0, 0, 64'h4444444444444444, 8'hff, 0);
        do_read(20, 1, 0);
        repeat (2) @(negedge clk);
        wait_ready();
        // Reset during the second beat of a four-beat read.
        do_read(4, 4, 0);
        do_reset(1);
        repeat (3) @(negedge clk);
        wait_ready();

        for (int t = 0; t < 80; t++) begin
            int sel = $urandom_range(9);
            int a = $urandom_range(31);
            int bc = $urandom_range(7);
            if (sel < 4) begin
                do_write(a, bc, $urandom_range(3, 1), $urandom_range(2), 1, '0, '0, $urandom_range(1));
            end else if (sel < 8) begin
                do_read(a, bc, 0);
            end else if (sel == 8) begin
                do_read(a, 4, 0);
                do_reset(1 + $urandom_range(1));
            end else begin
                do_write(a, bc, -1, 0, 1, '0, '0, 1);
            end
        end

        repeat (8) @(negedge clk);
        wait_ready();
        checks++;
        if (exp_rd.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d read beats outstanding, required 0", exp_rd.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
